mac_job_ctrl: RTL and testbench

Job controller and round-robin arbiter that shares one 8×8→16 MAC datapath between `N_REQ` requesters. Each requester submits a dot-product job of `len` operand pairs, streams the operands over a valid/ready channel, and receives the 16-bit accumulated result over a response channel. The controller clears the accumulator, gates the MAC enable per accepted beat, waits out the datapath pipeline latency, then captures and returns the result. It sits directly in front of the MAC datapath and its input pipeline flops, and replaces free-running enable usage.

---
 rtl/mac_ctrl_pkg.sv | 15 +
 rtl/mac_job_ctrl_rr_arbiter.sv | 32 +++
 rtl/mac_job_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mac_job_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC job controller.
package mac_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/mac_job_ctrl_rr_arbiter.sv
// N-way round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Rotating priority search starting at ptr
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mac_job_ctrl.sv
// Job controller sharing one 8x8->16 MAC between N_REQ requesters.
// Optional watchdog abort: define MAC_JOB_CTRL_WDOG_EN.
module mac_job_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          op_valid,
  input  logic [N_REQ*DATA_W-1:0]   op_a,
  input  logic [N_REQ*DATA_W-1:0]   op_b,
  output logic [N_REQ-1:0]          op_ready,
  output logic [N_REQ-1:0]          res_valid,
  input  logic [N_REQ-1:0]          res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic                      res_err,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      mac_en,
  output logic                      mac_clr,
  output logic [DATA_W-1:0]         mac_a,
  output logic [DATA_W-1:0]         mac_b,
  input  logic [ACC_W-1:0]          mac_c
);

  localparam int IW    = $clog2(N_REQ);
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  if (N_REQ < 2 || MAC_LAT < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mac_job_ctrl: N_REQ>=2, MAC_LAT>=1 and TIMEOUT>=1 required");
  end

  state_t             state_r, state_nxt_s;
  logic [IW-1:0]      grant_id_r, rr_ptr_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [LAT_W-1:0]   lat_r;
  logic [ACC_W-1:0]   res_data_r;
  logic [N_REQ-1:0]   arb_gnt_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_any_s;
  logic [LEN_W-1:0]   sel_len_s;
  logic               accept_s, beat_s, abort_s, drain_done_s, rsp_done_s;
  logic               stall_hit_s;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  assign sel_len_s = req_len[arb_idx_s*LEN_W +: LEN_W];
  assign busy      = (state_r != ST_IDLE);
  assign grant_id  = grant_id_r;
  assign res_data  = res_data_r;

  // Next-state decode and per-cycle handshake/datapath controls
  always_comb begin
    state_nxt_s  = state_r;
    req_ready    = '0;
    op_ready     = '0;
    res_valid    = '0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    mac_a        = '0;
    mac_b        = '0;
    accept_s     = 1'b0;
    beat_s       = 1'b0;
    abort_s      = 1'b0;
    drain_done_s = 1'b0;
    rsp_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // reset gate keeps a pending request from seeing a phantom accept pulse
        if (arb_any_s && !reset) begin
          accept_s    = 1'b1;
          req_ready   = arb_gnt_s;
          state_nxt_s = (sel_len_s == '0) ? ST_RESP : ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        mac_clr     = 1'b1;
        state_nxt_s = ST_STREAM;
      end
      ST_STREAM: begin
        op_ready[grant_id_r] = 1'b1;
        if (op_valid[grant_id_r]) begin
          beat_s      = 1'b1;
          mac_en      = 1'b1;
          mac_a       = op_a[grant_id_r*DATA_W +: DATA_W];
          mac_b       = op_b[grant_id_r*DATA_W +: DATA_W];
          state_nxt_s = (cnt_r == LEN_W'(1)) ? ST_DRAIN : ST_STREAM;
        end else if (stall_hit_s) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (lat_r == LAT_W'(MAC_LAT - 1)) begin
          drain_done_s = 1'b1;
          state_nxt_s  = ST_RESP;
        end else begin
          state_nxt_s  = ST_DRAIN;
        end
      end
      ST_RESP: begin
        res_valid[grant_id_r] = 1'b1;
        if (res_ready[grant_id_r]) begin
          rsp_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, job bookkeeping and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
      cnt_r      <= '0;
      lat_r      <= '0;
      res_data_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        grant_id_r <= arb_idx_s;
        cnt_r      <= sel_len_s;
        lat_r      <= '0;
        res_data_r <= '0;
      end else if (beat_s) begin
        cnt_r <= cnt_r - LEN_W'(1);
      end else if (state_r == ST_DRAIN) begin
        lat_r <= lat_r + LAT_W'(1);
        if (drain_done_s) begin
          res_data_r <= mac_c;
        end
      end else if (abort_s) begin
        res_data_r <= '0;
      end else if (rsp_done_s) begin
        rr_ptr_r <= (grant_id_r == IW'(N_REQ - 1)) ? '0 : grant_id_r + IW'(1);
      end
    end
  end

`ifdef MAC_JOB_CTRL_WDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_r;
  logic          res_err_r;

  assign stall_hit_s = (stall_r == SW'(TIMEOUT - 1));
  assign res_err     = res_err_r;

  // Stall watchdog: counts idle STREAM cycles, flags an aborted job
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r   <= '0;
      res_err_r <= 1'b0;
    end else begin
      if (state_r != ST_STREAM || beat_s) begin
        stall_r <= '0;
      end else begin
        stall_r <= stall_r + SW'(1);
      end
      if (accept_s) begin
        res_err_r <= 1'b0;
      end else if (abort_s) begin
        res_err_r <= 1'b1;
      end
    end
  end
`else
  assign stall_hit_s = 1'b0;
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Scoreboard bench for mac_job_ctrl with a behavioural 2-stage MAC model.
module tb_mac_job_ctrl;
  localparam int N = 2, LW = 8, LAT = 2, TO = 16;

  logic            clk = 1'b0, reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready, op_valid = '0, op_ready;
  logic [N-1:0]    res_valid, res_ready = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N*8-1:0]  op_a = '0, op_b = '0;
  logic [15:0]     res_data, mac_c;
  logic            res_err, busy, mac_en, mac_clr;
  logic [0:0]      grant_id;
  logic [7:0]      mac_a, mac_b;

  always #5 clk = ~clk;

  mac_job_ctrl #(.N_REQ(N), .LEN_W(LW), .MAC_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy), .grant_id(grant_id),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c)
  );

  // MAC datapath model: input flops then accumulator, result MAC_LAT=2 after enable
  logic [7:0]  a_q = 8'd0, b_q = 8'd0;
  logic        en_q = 1'b0, clr_q = 1'b0;
  logic [15:0] acc = 16'h1234;
  assign mac_c = acc;
  always @(posedge clk) begin
    a_q <= mac_a; b_q <= mac_b; en_q <= mac_en; clr_q <= mac_clr;
    if (clr_q) acc <= 16'd0;
    else if (en_q) acc <= acc + ({8'd0, a_q} * {8'd0, b_q});
  end

  int n_vec = 0, n_err = 0;
  int lenq[N][$], aq[N][$], bq[N][$], expq[N][$], errq[N][$];
  bit in_job[N], rv_seen[N];
  int acc_cyc[N], cur_len[N], left[N], stall_c[N];
  int cyc = 0, gap_mode = 0, hold = 0, clr_cnt = 0;
  bit lat_chk = 1'b1;
  int grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic add_job(input int r, input int len, input int kind);
    int a, b, sum;
    sum = 0;
    for (int k = 0; k < len; k++) begin
      if (kind == 0) begin a = 2*k + 1; b = 2*k + 2; end
      else if (kind == 1) begin a = 255; b = 255; end
      else begin a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); end
      aq[r].push_back(a); bq[r].push_back(b);
      sum += a * b;
    end
    lenq[r].push_back(len);
    expq[r].push_back((kind == 3) ? 0 : sum % 65536);
    errq[r].push_back((kind == 3) ? 1 : 0);
  endtask

  function automatic bit stall_ok(input int r);
`ifdef MAC_JOB_CTRL_WDOG_EN
    return stall_c[r] < TO;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int r = 0; r < N; r++) if (in_job[r] || lenq[r].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic abort_all();
    for (int r = 0; r < N; r++) begin
      lenq[r].delete(); aq[r].delete(); bq[r].delete(); expq[r].delete(); errq[r].delete();
      in_job[r] = 1'b0; left[r] = 0;
    end
  endtask

  // One cycle: drive at negedge, sample #1 later, posedge follows
  task automatic tick(input bit rst);
    logic [N-1:0] er;
    logic [15:0]  exp_ab;
    bit           beat_any, eclr, gap;
    @(negedge clk);
    reset = rst;
    gap = (gap_mode == 2) || (gap_mode == 1 && (cyc % 3 == 0));
    for (int r = 0; r < N; r++) begin
      er[r] = in_job[r] && (cyc >= acc_cyc[r] + 2) && (left[r] > 0) && stall_ok(r);
      req_valid[r] = !rst && !in_job[r] && (lenq[r].size() > 0);
      req_len[r*LW +: LW] = req_valid[r] ? LW'(lenq[r][0]) : '0;
      op_valid[r] = !rst && in_job[r] && (left[r] > 0) && !gap;
      op_a[r*8 +: 8] = op_valid[r] ? 8'(aq[r][0]) : 8'd0;
      op_b[r*8 +: 8] = op_valid[r] ? 8'(bq[r][0]) : 8'd0;
      res_ready[r] = (hold == 0);
    end
    #1;
    if (!rst) begin
      beat_any = 1'b0; exp_ab = 16'd0; eclr = 1'b0;
      for (int r = 0; r < N; r++) begin
        chk("op_ready", op_ready[r], er[r]);
        if (in_job[r] && cyc == acc_cyc[r] + 1) begin
          chk("grant_id", grant_id, r);
          if (cur_len[r] > 0) eclr = 1'b1;
        end
        if (er[r] && op_valid[r]) begin
          beat_any = 1'b1;
          exp_ab = {8'(aq[r][0]), 8'(bq[r][0])};
        end
      end
      chk("mac_en", mac_en, beat_any);
      chk("mac_ab", {mac_a, mac_b}, exp_ab);
      chk("mac_clr", mac_clr, eclr);
      if (mac_clr) clr_cnt++;
      for (int r = 0; r < N; r++) begin
        if (er[r] && op_valid[r]) begin
          void'(aq[r].pop_front()); void'(bq[r].pop_front());
          left[r]--; stall_c[r] = 0;
        end else if (er[r]) begin
          stall_c[r]++;
        end
        if (res_valid[r]) begin
          if (!in_job[r] || expq[r].size() == 0) begin
            chk("res_spurious", res_valid[r], 1'b0);
          end else begin
            if (!rv_seen[r] && lat_chk)
              chk("latency", cyc - acc_cyc[r], (cur_len[r] == 0) ? 1 : cur_len[r] + LAT + 2);
            rv_seen[r] = 1'b1;
            if (res_ready[r]) begin
              chk("res_data", res_data, expq[r].pop_front());
              chk("res_err", res_err, errq[r].pop_front());
              repeat (left[r]) begin void'(aq[r].pop_front()); void'(bq[r].pop_front()); end
              left[r] = 0; in_job[r] = 1'b0;
            end else begin
              chk("hold_data", res_data, expq[r][0]);
              chk("hold_busy", busy, 1'b1);
              chk("hold_no_req_ready", req_ready, '0);
              hold--;
            end
          end
        end
        if (req_ready[r]) begin
          chk("req_ready_valid", req_valid[r], 1'b1);
          if (req_valid[r]) begin
            grant_log.push_back(r);
            in_job[r] = 1'b1; acc_cyc[r] = cyc; rv_seen[r] = 1'b0;
            cur_len[r] = lenq[r].pop_front(); left[r] = cur_len[r]; stall_c[r] = 0;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int budget);
    int c = 0;
    while (pending() && c < budget) begin tick(1'b0); c++; end
    if (pending()) begin chk("run_timeout", 1'b1, 1'b0); abort_all(); end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk(tag, {req_ready, op_ready, res_valid, res_data, res_err, busy, grant_id,
              mac_en, mac_clr, mac_a, mac_b}, 64'd0);
  endtask

  initial begin
    int c;
    tick(1'b1); tick(1'b1); tick(1'b0);
    chk_zero_outs("reset_outputs");

    // Basic job: (1,2),(3,4),(5,6) -> 44, single clear pulse
    clr_cnt = 0;
    add_job(0, 3, 0);
    run(50);
    chk("clr_pulses", clr_cnt, 1);

    // Fairness from reset: both requesting, grants alternate 0,1,0,1
    tick(1'b1); tick(1'b0);
    grant_log.delete();
    add_job(0, 2, 2); add_job(1, 1, 2); add_job(0, 1, 2); add_job(1, 2, 2);
    run(200);
    chk("grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("grant_order", grant_log[i], i % 2);

    // Wrap-around and zero-length jobs
    add_job(0, 2, 1); add_job(1, 0, 2); add_job(0, 0, 2);
    run(100);

    // Response backpressure with a competing request pending
    hold = 10;
    add_job(0, 3, 2); add_job(1, 2, 2);
    run(100);
    chk("hold_consumed", hold, 0);
    hold = 0;

    // Operand gaps
    lat_chk = 1'b0; gap_mode = 1;
    add_job(0, 5, 2); add_job(1, 4, 2);
    run(200);
    gap_mode = 0; lat_chk = 1'b1;

    // Reset after 2 of 4 beats, then a fresh job
    add_job(0, 4, 2);
    c = 0;
    while (!(in_job[0] && left[0] == 2) && c < 30) begin tick(1'b0); c++; end
    chk("midstream_reached", (in_job[0] && left[0] == 2), 1'b1);
    abort_all();
    tick(1'b1); tick(1'b0);
    chk_zero_outs("midstream_reset_outputs");
    add_job(0, 3, 2);
    run(50);

`ifdef MAC_JOB_CTRL_WDOG_EN
    // Watchdog abort, then error cleared by the next job
    lat_chk = 1'b0; gap_mode = 2;
    add_job(1, 2, 3);
    run(100);
    gap_mode = 0; lat_chk = 1'b1;
    add_job(1, 1, 2);
    run(50);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
